// File: rtl/sublime_pkg.sv
// Shared types and constants for the voice sequencer: FSM state encoding,
// velocity/sample widths and the default acknowledge timeout.
package sublime_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EMIT = 2'd2
  } seq_state_t;

  localparam int VEL_W           = 8;
  localparam int DATA_W          = 32;
  localparam int DEF_ACK_TIMEOUT = 15;

endpackage

// File: rtl/sublime_velocity_table.sv
// Per-voice velocity register file: one synchronous write port, one
// asynchronous read port, all entries reset to 0.
module sublime_velocity_table
  import sublime_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  localparam int VW = $clog2(NUM_VOICES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [VW-1:0]    waddr,
  input  logic [VEL_W-1:0] wdata,
  input  logic [VW-1:0]    raddr,
  output logic [VEL_W-1:0] rdata
);

  logic [VEL_W-1:0] vel [NUM_VOICES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) vel[i] <= '0;
    end else if (we) begin
      vel[waddr] <= wdata;
    end
  end

  // A same-cycle write is not yet visible here, so readers get the old value.
  assign rdata = vel[raddr];

endmodule

// File: rtl/sublime_voice_sequencer.sv
// Per-sample frame controller: walks voices N-1..0 over a req/ack handshake and
// presents each sample to the mixer. Optional ack timeout: SUBLIME_VOICE_SEQ_TIMEOUT_EN.
module sublime_voice_sequencer
  import sublime_pkg::*;
#(
  parameter int NUM_VOICES  = 8,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  localparam int VW = $clog2(NUM_VOICES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic              vel_we,
  input  logic [VW-1:0]     vel_addr,
  input  logic [VEL_W-1:0]  vel_wdata,
  output logic              gen_req,
  output logic [VW-1:0]     gen_voice,
  input  logic              gen_ack,
  input  logic [DATA_W-1:0] gen_data,
  output logic [VW-1:0]     active_voice,
  output logic              active_voice_changed,
  output logic [VEL_W-1:0]  active_voice_velocity,
  output logic [DATA_W-1:0] active_voice_data,
  output logic              busy,
  output logic              overrun,
  output logic              timeout,
  input  logic              flags_clr,
  output logic [1:0]        dbg_state
);

  // Handshake: gen_req/gen_voice are held while in REQ; the first cycle with
  // gen_ack high transfers gen_data and ends the request. Acks outside REQ are ignored.

  seq_state_t       state, next_state;
  logic [VW-1:0]    idx, idx_nxt;
  logic [VEL_W-1:0] vel_rdata;
  logic             capture, cap_zero, to_hit, overrun_set;

  sublime_velocity_table #(.NUM_VOICES(NUM_VOICES)) u_vel (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (vel_we),
    .waddr (vel_addr),
    .wdata (vel_wdata),
    .raddr (idx),
    .rdata (vel_rdata)
  );

  always_comb begin
    next_state = state;
    idx_nxt    = idx;
    capture    = 1'b0;
    cap_zero   = 1'b0;
    case (state)
      IDLE: if (sample_tick) begin
        next_state = REQ;
        idx_nxt    = VW'(NUM_VOICES - 1);
      end
      REQ: if (gen_ack) begin
        next_state = EMIT;
        capture    = 1'b1;
      end else if (to_hit) begin
        next_state = EMIT;
        capture    = 1'b1;
        cap_zero   = 1'b1;
      end
      EMIT: if (idx == '0) begin
        next_state = IDLE;
      end else begin
        next_state = REQ;
        idx_nxt    = idx - VW'(1);
      end
      default: next_state = IDLE;
    endcase
  end

  assign overrun_set = sample_tick && (state != IDLE);
  assign gen_req     = (state == REQ);
  assign gen_voice   = idx;
  assign dbg_state   = state;

  // Mixer-side outputs are loaded on the edge entering EMIT so the strobe
  // cycle already carries the voice, velocity and sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      idx                   <= '0;
      busy                  <= 1'b0;
      active_voice          <= '0;
      active_voice_changed  <= 1'b0;
      active_voice_velocity <= '0;
      active_voice_data     <= '0;
      overrun               <= 1'b0;
    end else begin
      state                <= next_state;
      idx                  <= idx_nxt;
      busy                 <= (next_state != IDLE);
      active_voice_changed <= capture;
      if (capture) begin
        active_voice          <= idx;
        active_voice_velocity <= vel_rdata;
        active_voice_data     <= cap_zero ? '0 : gen_data;
      end
      overrun <= overrun_set | (overrun & ~flags_clr);
    end
  end

`ifdef SUBLIME_VOICE_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  // wait_cnt counts completed REQ cycles of the current request only.
  assign to_hit = (wait_cnt == CNT_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      wait_cnt <= (state == REQ && next_state == REQ) ? wait_cnt + CNT_W'(1) : '0;
      timeout  <= (state == REQ && !gen_ack && to_hit) | (timeout & ~flags_clr);
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/sublime_voice_sequencer.md
# sublime_voice_sequencer

Per-sample frame controller for the voice mixer. On each sample tick it walks every voice from `NUM_VOICES-1` down to 0, requests that voice's sample from the voice generators over a req/ack handshake, and presents it to the mixer with the voice's velocity. Voice 0 is always presented last, which closes the mixer's frame and updates its mixed output. A register-based velocity table, written by the control interface, is held here.

## Interface

Parameters:
- `NUM_VOICES`, 8: voice count; power of two, ≥2. `VW = $clog2(NUM_VOICES)`.
- `ACK_TIMEOUT`, 15: maximum wait cycles for `gen_ack`. Used only with the timeout feature.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sample_tick`  in  1  single-cycle pulse that starts a frame.
- `vel_we`  in  1  velocity table write strobe.
- `vel_addr`  in  VW  velocity table write index.
- `vel_wdata`  in  8  signed velocity value.
- `gen_req`  out  1  sample request to the voice generators.
- `gen_voice`  out  VW  voice index being requested.
- `gen_ack`  in  1  generator acknowledge; `gen_data` is valid in this cycle.
- `gen_data`  in  32  signed voice sample.
- `active_voice`  out  VW  voice index presented to the mixer.
- `active_voice_changed`  out  1  one-cycle strobe; the mixer samples on it.
- `active_voice_velocity`  out  8  velocity for `active_voice`.
- `active_voice_data`  out  32  sample for `active_voice`.
- `busy`  out  1  high while a frame is in progress.
- `overrun`  out  1  sticky flag: a tick was dropped.
- `timeout`  out  1  sticky flag: an acknowledge timed out (tied to 0 when the timeout feature is compiled out).
- `flags_clr`  in  1  clears `overrun` and `timeout`.

## Operation

- FSM states: `IDLE`, `REQ`, `EMIT`.
  - `IDLE`: on `sample_tick`, load `idx = NUM_VOICES-1` and go to `REQ`.
  - `REQ`: drive `gen_req=1` and `gen_voice=idx`. When `gen_ack=1`, capture `gen_data` into `active_voice_data` and go to `EMIT`. `gen_req` stays high until the ack.
  - `EMIT`: drive `active_voice=idx`, `active_voice_velocity=vel[idx]`, and `active_voice_changed=1` for exactly this cycle. If `idx==0`, go to `IDLE`; otherwise decrement `idx` and go to `REQ`.
- All mixer-side outputs are registered. `active_voice`, velocity and data hold their values between strobes.
- `busy = (state != IDLE)`, registered.
- Any `sample_tick` while `busy=1` is ignored and sets `overrun`. This includes a tick in the `EMIT` cycle of voice 0.
- Velocity table:
  - `NUM_VOICES` × 8-bit registers, written on `vel_we`; a write takes effect on the next cycle.
  - A read in `EMIT` that coincides with a write to the same index returns the old value.
  - Writes are permitted at any time, including mid-frame.
- Flags:
  - If a set event and `flags_clr` occur in the same cycle, set wins.
  - Flags are never cleared by the frame logic itself.
- Reset:
  - State returns to `IDLE`, `idx=0`, and every output reads 0.
  - All velocity registers read 0.
  - Reset mid-frame abandons the frame. No voice-0 strobe is issued, so the mixer's output is not updated.

## Timing

- `sample_tick` at cycle T: `busy=1` and `gen_req=1` (voice N-1) from T+1.
- Ack in cycle A: `EMIT` (strobe) occurs in cycle A+1. The next `REQ` is at A+2.
- `gen_ack` may be tied high. Minimum cost is then 2 cycles per voice, so a full frame takes `2*NUM_VOICES` cycles.
- `busy` falls in the cycle after voice 0's `EMIT`. A tick in that cycle is accepted.
- `gen_ack` arriving while not in `REQ` is ignored.

## Configuration

- `SUBLIME_VOICE_SEQ_TIMEOUT_EN` defined:
  - A wait counter runs in `REQ`.
  - If `ACK_TIMEOUT` cycles elapse without `gen_ack`, the captured data is forced to 0, `timeout` is set, and the FSM proceeds to `EMIT`.
  - The counter clears on entry to each `REQ`.
- Macro undefined: `REQ` waits indefinitely and `timeout` is constant 0.

## Structure

- A shared package `sublime_pkg` holds:
  - the FSM state enum,
  - the velocity and sample width constants (8, 32),
  - the default `ACK_TIMEOUT`.
- One natural sub-module, `sublime_velocity_table`: a register file with one write port and one async read port, reset to 0.

## Test plan

- **Full frame, ack tied high.** `NUM_VOICES=8`, write `vel[i]=i+1`, `gen_data = voice*100`, one tick → 8 strobes in order 7..0, one every 2 cycles. Voice 3 presents velocity 4 and data 300. `busy` is high for 16 cycles.
- **Delayed ack.** Voice 5 acks after 4 cycles → `gen_req` held high for 4 cycles with `gen_voice=5`. The strobe appears the cycle after the ack.
- **Overrun.** Tick again at T+5 and in voice 0's `EMIT` cycle → both ignored and `overrun=1`. Then `flags_clr` → `overrun=0`. A tick the cycle after `busy` falls starts a new frame.
- **Velocity write collision.** Write `vel[2]=0x7F` in the same cycle as voice 2's `EMIT` → the old value is emitted. The next frame emits `0x7F`.
- **Timeout (macro on).** Voice 4 never acks → after 15 cycles voice 4 is emitted with data 0 and `timeout=1`, and the frame completes.
- **Reset mid-frame.** Assert `rst_n=0` during voice 3's `REQ` → all outputs 0 asynchronously and `vel[*]=0`. After release, no strobe occurs until the next tick.
